// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, the HALT opcode and the
// {instr, pc} entry carried through the fetch buffer.
package cpu_pkg;

  localparam int ADDR_WIDTH  = 8;
  localparam int INSTR_WIDTH = 16;

  localparam logic [3:0] HALT_OPCODE = 4'hF;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry buffer between the ROM return path and decode.
// Flush wins over push and pop.
module fetch_skid_fifo #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  // The head slot always holds the oldest entry, so the output never needs a mux.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) head_d = data_i;
          else                 tail_d = data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = data_i;
          end else begin
            head_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign data_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, ROM address, one-cycle ROM latency tracking
// and a 2-entry output buffer to decode. Optional halt detection: FETCH_HALT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                        ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
  parameter int                        INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]     RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc
);

  localparam int EntryWidth = INSTR_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic [EntryWidth-1:0] head;
  logic [1:0]            count;
  logic [2:0]            occupancy;
  logic                  pop, push, issue, halt_hit, halted;

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Occupancy after this edge counts the in-flight word, so issuing only when it
  // is at most 1 leaves room for the word we are about to request.
  always_comb begin
    pop       = instr_valid & instr_ready & ~redirect;
    occupancy = {1'b0, count} - {2'b00, instr_valid & instr_ready} + {2'b00, inflight_q};
    issue     = ~redirect & ~halted & (occupancy <= 3'd1);
    push      = inflight_q & ~redirect;
`ifdef FETCH_HALT_EN
    halt_hit  = push & (rom_instr[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
`else
    halt_hit  = 1'b0;
`endif

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue & ~halt_hit;
    inflight_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef FETCH_HALT_EN
  // Halt sticks until a redirect restarts fetch somewhere else.
  always_comb begin
    halted_d = halted_q | halt_hit;
    if (redirect) halted_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end
`endif

  fetch_skid_fifo #(
    .WIDTH(EntryWidth)
  ) u_buffer (
    .clk    (clk),
    .rst    (rst),
    .flush_i(redirect),
    .push_i (push),
    .pop_i  (pop),
    .data_i ({rom_instr, inflight_pc_q}),
    .data_o (head),
    .count_o(count)
  );

  assign rom_addr    = fetch_pc_q;
  assign instr_valid = (count != 2'd0);
  assign instr       = head[EntryWidth-1 -: INSTR_WIDTH];
  assign instr_pc    = head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered-read ROM model.
// Halt scenario is exercised only when FETCH_HALT_EN is defined.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic [INSTR_WIDTH-1:0] rom_instr = '0;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirect_pc;

  logic [INSTR_WIDTH-1:0] rom [256];
  int checkCount = 0;
  int passCount  = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_instr  (rom_instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: address sampled on the edge, data valid the following cycle.
  always @(posedge clk) rom_instr <= rom[rom_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Drive one cycle's inputs, then advance to 1ns past the next rising edge.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [ADDR_WIDTH-1:0] rpc);
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  // Expect n consecutive deliveries starting at startPc with ready held high.
  task automatic streamCheck(input logic [ADDR_WIDTH-1:0] startPc, input int n);
    fetch_entry_t exp;
    exp.pc = startPc;
    for (int i = 0; i < n; i++) begin
      exp.instr = rom[exp.pc];
      checkOutput($sformatf("valid@%0h", exp.pc), {31'b0, instr_valid}, 32'd1);
      checkOutput($sformatf("pc@%0h", exp.pc), {24'b0, instr_pc}, {24'b0, exp.pc});
      checkOutput($sformatf("instr@%0h", exp.pc), {16'b0, instr}, {16'b0, exp.instr});
      applyStimulus(1'b1, 1'b0, '0);
      exp.pc = exp.pc + 8'd1;
    end
  endtask

  // Release reset and expect the two-cycle latency before PC 0 appears.
  task automatic startupCheck();
    rst = 1'b0;
    checkOutput("lat0_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("lat1_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("lat1_addr", {24'b0, rom_addr}, 32'd1);
    applyStimulus(1'b1, 1'b0, '0);
    streamCheck(8'h00, 4);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
    rst = 1'b1;
    instr_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    #1;
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_addr", {24'b0, rom_addr}, 32'd0);
    checkOutput("rst_instr", {16'b0, instr}, 32'd0);
    checkOutput("rst_pc", {24'b0, instr_pc}, 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);

    startupCheck();

    checkOutput("pre_stall_pc", {24'b0, instr_pc}, 32'h4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("stall_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("stall_pc", {24'b0, instr_pc}, 32'h4);
      checkOutput("stall_instr", {16'b0, instr}, 32'h1004);
      checkOutput("stall_addr", {24'b0, rom_addr}, 32'h6);
    end
    streamCheck(8'h04, 5);

    applyStimulus(1'b1, 1'b1, 8'h40);
    checkOutput("redir_r_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("redir_r_addr", {24'b0, rom_addr}, 32'h40);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("redir_r1_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    streamCheck(8'h40, 3);

    applyStimulus(1'b1, 1'b1, 8'hFE);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    streamCheck(8'hFE, 4);

    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("arst_addr", {24'b0, rom_addr}, 32'd0);
    checkOutput("arst_pc", {24'b0, instr_pc}, 32'd0);
    checkOutput("arst_instr", {16'b0, instr}, 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    startupCheck();

`ifdef FETCH_HALT_EN
    rom[2] = 16'hF000;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, '0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    streamCheck(8'h00, 3);
    for (int i = 0; i < 20; i++) begin
      checkOutput("halt_valid", {31'b0, instr_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, '0);
    end
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    streamCheck(8'h00, 2);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
